// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline-side request/response signals and memory-side strobes
// shared by the unified-memory arbiter and its clients.
interface mem_port_arbiter_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16
);
  logic              halt;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [WORD_W-1:0] i_data;
  logic              i_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic [WORD_W-1:0] d_rdata;
  logic              d_valid;
  logic              stall_if;
  logic              stall_mem;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_data;

  modport slave (
    input  halt, i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data,
    output i_data, i_valid, d_rdata, d_valid, stall_if, stall_mem,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output halt, i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data,
    input  i_data, i_valid, d_rdata, d_valid, stall_if, stall_mem,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one fixed-latency memory.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed D-over-I.
module mem_port_arbiter #(
  parameter int WORD_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_i_data;
  logic [WORD_W-1:0] r_d_rdata;
  logic              r_i_valid;
  logic              r_d_valid;

  logic w_accept;
  logic w_grant_d;
  logic w_busy_i;
  logic w_busy_d;
  logic w_last;

  assign w_accept = (r_state == S_IDLE) & ~bus.halt & (bus.i_req | bus.d_req);
  assign w_busy_i = (r_state == S_BUSY_I);
  assign w_busy_d = (r_state == S_BUSY_D);
  assign w_last   = (r_cnt == CNT_ONE);

`ifdef MEM_ARB_RR_EN
  // 0 = I, 1 = D; on a tie the port that did not win last time goes first
  logic r_last_grant;

  assign w_grant_d = bus.d_req & (~bus.i_req | ~r_last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b0;
    end else if (w_accept) begin
      r_last_grant <= w_grant_d;
    end
  end
`else
  assign w_grant_d = bus.d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_i_data  <= '0;
      r_d_rdata <= '0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
    end else begin
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= CNT_LOAD;
            if (w_grant_d) begin
              r_state <= S_BUSY_D;
              r_addr  <= bus.d_addr;
              r_we    <= bus.d_we;
              r_wdata <= bus.d_wdata;
            end else begin
              r_state <= S_BUSY_I;
              r_addr  <= bus.i_addr;
              r_we    <= 1'b0;
            end
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (w_last) begin
            r_state <= S_IDLE;
            if (w_busy_i) begin
              r_i_data  <= bus.mem_data;
              r_i_valid <= 1'b1;
            end else begin
              // stores complete with a pulse but leave the load register intact
              if (!r_we) begin
                r_d_rdata <= bus.mem_data;
              end
              r_d_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.mem_read  = w_busy_i | (w_busy_d & ~r_we);
  assign bus.mem_write = w_busy_d & r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.i_data    = r_i_data;
  assign bus.i_valid   = r_i_valid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_valid   = r_d_valid;
  assign bus.stall_if  = bus.i_req & ~r_i_valid;
  assign bus.stall_mem = bus.d_req & ~r_d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency memory model that
// only presents real data in the last access cycle.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst;
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  logic [15:0] mem [0:255];

  mem_port_arbiter_if #(.WORD_W(16), .ADDR_W(16)) bus ();

  mem_port_arbiter #(.WORD_W(16), .ADDR_W(16), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_cnt <= bus.mem_read ? rd_cnt + 1 : 0;
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
  assign bus.mem_data = (bus.mem_read && rd_cnt == LAT - 1) ? mem[bus.mem_addr[7:0]] : 16'hDEAD;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.halt = 1'b0; bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    tick; tick;
    checks++;
    if ({bus.i_valid, bus.d_valid, bus.mem_read, bus.mem_write, bus.stall_if, bus.stall_mem} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000",
        {bus.i_valid, bus.d_valid, bus.mem_read, bus.mem_write, bus.stall_if, bus.stall_mem});
    end
    checks++;
    if ({bus.i_data, bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
      errors++; $display("FAIL reset_words: got %h expected 0",
        {bus.i_data, bus.d_rdata, bus.mem_addr, bus.mem_wdata});
    end
    bus.i_req = 1'b1;
    tick;
    checks++;
    if (bus.mem_read !== 1'b0) begin
      errors++; $display("FAIL reset_no_accept: mem_read got %b expected 0", bus.mem_read);
    end
    bus.i_req = 1'b0;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_fetch;
    bus.i_req = 1'b1; bus.i_addr = 16'h0000;
    tick;
    checks++;
    if ({bus.mem_read, bus.i_valid, bus.stall_if} !== 3'b101 || bus.mem_addr !== 16'h0000) begin
      errors++; $display("FAIL fetch_busy1: rd/iv/stall got %b addr %h expected 101 addr 0000",
        {bus.mem_read, bus.i_valid, bus.stall_if}, bus.mem_addr);
    end
    tick;
    checks++;
    if (bus.mem_read !== 1'b1 || bus.i_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_busy2: rd %b iv %b expected 1 0", bus.mem_read, bus.i_valid);
    end
    tick;
    checks++;
    if ({bus.mem_read, bus.i_valid, bus.stall_if} !== 3'b010 || bus.i_data !== 16'h6000) begin
      errors++; $display("FAIL fetch_valid: rd/iv/stall got %b data %h expected 010 data 6000",
        {bus.mem_read, bus.i_valid, bus.stall_if}, bus.i_data);
    end
    bus.i_req = 1'b0;
    tick;
    checks++;
    if (bus.i_valid !== 1'b0 || bus.i_data !== 16'h6000) begin
      errors++; $display("FAIL fetch_pulse_width: iv %b data %h expected 0 6000", bus.i_valid, bus.i_data);
    end
  endtask

  task automatic test_both_requests;
    bus.i_req = 1'b1; bus.i_addr = 16'h0004;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0010;
    tick;
    checks++;
    if (bus.mem_addr !== 16'h0010 || bus.mem_read !== 1'b1 || {bus.stall_if, bus.stall_mem} !== 2'b11) begin
      errors++; $display("FAIL both_d_first: addr %h rd %b stalls %b expected 0010 1 11",
        bus.mem_addr, bus.mem_read, {bus.stall_if, bus.stall_mem});
    end
    tick;
    tick;
    checks++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 16'hBEEF || {bus.stall_if, bus.stall_mem} !== 2'b10) begin
      errors++; $display("FAIL both_d_valid: dv %b data %h stalls %b expected 1 beef 10",
        bus.d_valid, bus.d_rdata, {bus.stall_if, bus.stall_mem});
    end
    bus.d_req = 1'b0;
    tick;
    checks++;
    if (bus.mem_addr !== 16'h0004 || bus.mem_read !== 1'b1 || bus.stall_if !== 1'b1) begin
      errors++; $display("FAIL both_i_granted: addr %h rd %b stall_if %b expected 0004 1 1",
        bus.mem_addr, bus.mem_read, bus.stall_if);
    end
    tick;
    tick;
    checks++;
    if (bus.i_valid !== 1'b1 || bus.i_data !== 16'h7004 || bus.d_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL both_i_valid: iv %b idata %h drdata %h expected 1 7004 beef",
        bus.i_valid, bus.i_data, bus.d_rdata);
    end
    bus.i_req = 1'b0;
    tick;
  endtask

  task automatic test_store;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0020; bus.d_wdata = 16'h1234;
    checks++;
    if (bus.mem_write !== 1'b0) begin
      errors++; $display("FAIL store_pre: mem_write got %b expected 0", bus.mem_write);
    end
    for (int c = 0; c < 2; c++) begin
      tick;
      checks++;
      if ({bus.mem_write, bus.mem_read} !== 2'b10 || bus.mem_addr !== 16'h0020 || bus.mem_wdata !== 16'h1234) begin
        errors++; $display("FAIL store_busy%0d: wr/rd %b addr %h wdata %h expected 10 0020 1234",
          c, {bus.mem_write, bus.mem_read}, bus.mem_addr, bus.mem_wdata);
      end
    end
    tick;
    checks++;
    if (bus.mem_write !== 1'b0 || bus.d_valid !== 1'b1 || bus.d_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL store_done: wr %b dv %b drdata %h expected 0 1 beef",
        bus.mem_write, bus.d_valid, bus.d_rdata);
    end
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    tick;
    checks++;
    if (mem[8'h20] !== 16'h1234 || bus.d_valid !== 1'b0) begin
      errors++; $display("FAIL store_memory: mem %h dv %b expected 1234 0", mem[8'h20], bus.d_valid);
    end
  endtask

  task automatic test_reset_mid_access;
    bus.i_req = 1'b1; bus.i_addr = 16'h0008;
    tick;
    checks++;
    if (bus.mem_read !== 1'b1) begin
      errors++; $display("FAIL midrst_busy: mem_read got %b expected 1", bus.mem_read);
    end
    #2;
    rst = 1'b1; bus.i_req = 1'b0;
    #1;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.i_data !== 16'h0000 || bus.mem_addr !== 16'h0000) begin
      errors++; $display("FAIL midrst_drop: rd %b idata %h addr %h expected 0 0000 0000",
        bus.mem_read, bus.i_data, bus.mem_addr);
    end
    for (int c = 0; c < 2; c++) begin
      tick;
      checks++;
      if (bus.i_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_no_valid%0d: iv got %b expected 0", c, bus.i_valid);
      end
    end
    rst = 1'b0;
    tick;
    bus.i_req = 1'b1; bus.i_addr = 16'h0008;
    tick; tick; tick;
    checks++;
    if (bus.i_valid !== 1'b1 || bus.i_data !== 16'h5A5A) begin
      errors++; $display("FAIL midrst_refetch: iv %b data %h expected 1 5a5a", bus.i_valid, bus.i_data);
    end
    bus.i_req = 1'b0;
    tick;
  endtask

  task automatic test_halt;
    bus.halt = 1'b1; bus.i_req = 1'b1; bus.i_addr = 16'h0000;
    for (int c = 0; c < 10; c++) begin
      tick;
      checks++;
      if ({bus.mem_read, bus.mem_write, bus.i_valid, bus.stall_if} !== 4'b0001) begin
        errors++; $display("FAIL halt_idle%0d: rd/wr/iv/stall got %b expected 0001",
          c, {bus.mem_read, bus.mem_write, bus.i_valid, bus.stall_if});
      end
    end
    bus.halt = 1'b0; bus.i_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0020;
    tick;
    bus.halt = 1'b1;
    tick;
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_addr !== 16'h0020) begin
      errors++; $display("FAIL halt_busy: rd %b addr %h expected 1 0020", bus.mem_read, bus.mem_addr);
    end
    tick;
    checks++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 16'h1234) begin
      errors++; $display("FAIL halt_complete: dv %b data %h expected 1 1234", bus.d_valid, bus.d_rdata);
    end
    bus.d_req = 1'b0; bus.i_req = 1'b1;
    tick; tick;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.d_valid !== 1'b0) begin
      errors++; $display("FAIL halt_after: rd %b dv %b expected 0 0", bus.mem_read, bus.d_valid);
    end
    bus.halt = 1'b0; bus.i_req = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic exp_d;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 16'h0004;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0010;
    for (int k = 0; k < 4; k++) begin
      exp_d = RR ? (k % 2 == 0) : 1'b1;
      tick;
      checks++;
      if (bus.mem_addr !== (exp_d ? 16'h0010 : 16'h0004) || bus.mem_read !== 1'b1) begin
        errors++; $display("FAIL b2b_grant%0d: addr %h rd %b expected %h 1",
          k, bus.mem_addr, bus.mem_read, exp_d ? 16'h0010 : 16'h0004);
      end
      tick;
      tick;
      checks++;
      if ({bus.d_valid, bus.i_valid} !== {exp_d, ~exp_d} ||
          (exp_d ? bus.d_rdata : bus.i_data) !== (exp_d ? 16'hBEEF : 16'h7004)) begin
        errors++; $display("FAIL b2b_valid%0d: dv/iv %b drdata %h idata %h expected %b",
          k, {bus.d_valid, bus.i_valid}, bus.d_rdata, bus.i_data, {exp_d, ~exp_d});
      end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick; tick; tick;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    mem[8'h00] = 16'h6000;
    mem[8'h04] = 16'h7004;
    mem[8'h08] = 16'h5A5A;
    mem[8'h10] = 16'hBEEF;
    test_reset;
    test_fetch;
    test_both_requests;
    test_store;
    test_reset_mid_access;
    test_halt;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
